// File: rtl/ssemi_fir_ctrl_pkg.sv
// Shared types and constants for the decimation-chain FIR coefficient control path.
// Build option: SSEMI_FIR_COEFF_SYMMETRIC_EN selects symmetric (half-bank) coefficient loading.
package ssemi_fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ARMED  = 2'd2,
        COMMIT = 2'd3
    } coeff_ctrl_state_e;

    // Sticky error bit positions
    localparam int unsigned ERR_W          = 3;
    localparam int unsigned ERR_ADDR       = 0;
    localparam int unsigned ERR_INCOMPLETE = 1;
    localparam int unsigned ERR_TIMEOUT    = 2;

    // Coefficient word as seen by the FIR
    localparam int unsigned COEFF_WIDTH_DEFAULT = 16;
    typedef logic signed [COEFF_WIDTH_DEFAULT-1:0] coeff_t;

    // Number of independently writable taps; symmetric builds load only the lower half
    function automatic int unsigned tap_limit(int unsigned num_taps);
`ifdef SSEMI_FIR_COEFF_SYMMETRIC_EN
        return (num_taps + 1) / 2;
`else
        return num_taps;
`endif
    endfunction

endpackage

// File: rtl/ssemi_coeff_shadow_bank.sv
// Shadow and active coefficient banks, per-tap write mask and mask-full detect.
// Build option: SSEMI_FIR_COEFF_SYMMETRIC_EN mirrors each write to tap NUM_TAPS-1-k.
module ssemi_coeff_shadow_bank
    import ssemi_fir_ctrl_pkg::*;
#(
    parameter int unsigned NUM_TAPS    = 64,
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned ADDR_W      = $clog2(NUM_TAPS)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            wr_en,        // legal, accepted write
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [COEFF_WIDTH-1:0]          wr_data,
    input  logic                            mask_clr,
    input  logic                            load_active,  // shadow <= active (restore)
    input  logic                            commit_bank,  // active <= shadow
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff,
    output logic                            mask_full     // includes a write in this cycle
);

    localparam int unsigned MASK_N = tap_limit(NUM_TAPS);

    logic [COEFF_WIDTH-1:0] shadow [NUM_TAPS];
    logic [COEFF_WIDTH-1:0] active [NUM_TAPS];
    logic [MASK_N-1:0]      mask_q;
    logic [NUM_TAPS-1:0]    tap_hit;
    logic [MASK_N-1:0]      mask_hit;

    // Decode the write address into per-tap and per-mask-bit strobes
    always_comb begin
        tap_hit  = '0;
        mask_hit = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            tap_hit[i] = wr_en && (wr_addr == ADDR_W'(i));
`ifdef SSEMI_FIR_COEFF_SYMMETRIC_EN
            if (wr_en && (wr_addr == ADDR_W'(NUM_TAPS - 1 - i))) begin
                tap_hit[i] = 1'b1;
            end
`endif
        end
        for (int i = 0; i < MASK_N; i++) begin
            mask_hit[i] = wr_en && (wr_addr == ADDR_W'(i));
        end
    end

    assign mask_full = &(mask_q | mask_hit);

    // Shadow bank: tap writes, or a bulk copy of the active bank for restore
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) shadow[i] <= '0;
        end else if (load_active) begin
            for (int i = 0; i < NUM_TAPS; i++) shadow[i] <= active[i];
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (tap_hit[i]) shadow[i] <= wr_data;
            end
        end
    end

    // Active bank only moves on a commit, so the FIR input never glitches
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) active[i] <= '0;
        end else if (commit_bank) begin
            for (int i = 0; i < NUM_TAPS; i++) active[i] <= shadow[i];
        end
    end

    // Write mask, clear wins over set
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mask_q <= '0;
        end else if (mask_clr) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_q | mask_hit;
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
        assign coeff[g*COEFF_WIDTH +: COEFF_WIDTH] = active[g];
    end

endmodule

// File: rtl/ssemi_fir_coeff_ctrl.sv
// FIR coefficient bank controller: load session, atomic commit at a safe boundary,
// and automatic re-commit of the active bank after the FIR is re-enabled.
// Build option: SSEMI_FIR_COEFF_SYMMETRIC_EN (see ssemi_fir_ctrl_pkg / ssemi_coeff_shadow_bank).
module ssemi_fir_coeff_ctrl
    import ssemi_fir_ctrl_pkg::*;
#(
    parameter int unsigned NUM_TAPS         = 64,
    parameter int unsigned COEFF_WIDTH      = 16,
    parameter int unsigned BOUNDARY_TIMEOUT = 1024,
    parameter int unsigned ADDR_W           = $clog2(NUM_TAPS)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_enable,
    input  logic                            i_start,
    input  logic                            i_wr_valid,
    output logic                            o_wr_ready,
    input  logic [ADDR_W-1:0]               i_wr_addr,
    input  logic [COEFF_WIDTH-1:0]          i_wr_data,
    input  logic                            i_commit,
    input  logic                            i_abort,
    input  logic                            i_fir_busy,
    input  logic                            i_fir_coeff_ready,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] o_coeff,
    output logic                            o_coeff_valid,
    output logic                            o_commit_done,
    output logic                            o_bank_id,
    output logic [1:0]                      o_state,
    output logic [2:0]                      o_error
);

    localparam int unsigned       TAP_LIMIT  = tap_limit(NUM_TAPS);
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(TAP_LIMIT);
    localparam int unsigned       CNT_W      = $clog2(BOUNDARY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BOUNDARY_TIMEOUT - 1);

    coeff_ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ERR_W-1:0]  error_q, error_d;
    logic              restore_pend_q, restore_pend_d;
    logic              restoring_q, restoring_d;
    logic              bank_id_q, bank_id_d;
    logic              enable_q;
    logic              commit_done_q;

    logic wr_fire, addr_ok, window_open;
    logic mask_clr, load_active, commit_bank, mask_full;

    assign wr_fire     = i_wr_valid && o_wr_ready;
    assign addr_ok     = ({1'b0, i_wr_addr} < ADDR_LIMIT);
    assign window_open = i_fir_coeff_ready && !i_fir_busy;

    ssemi_coeff_shadow_bank #(
        .NUM_TAPS    (NUM_TAPS),
        .COEFF_WIDTH (COEFF_WIDTH),
        .ADDR_W      (ADDR_W)
    ) u_bank (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .wr_en       (wr_fire && addr_ok),
        .wr_addr     (i_wr_addr),
        .wr_data     (i_wr_data),
        .mask_clr    (mask_clr),
        .load_active (load_active),
        .commit_bank (commit_bank),
        .coeff       (o_coeff),
        .mask_full   (mask_full)
    );

    // Next-state, error, timeout and restore bookkeeping
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        error_d        = error_q;
        restore_pend_d = restore_pend_q;
        restoring_d    = restoring_q;
        bank_id_d      = bank_id_q;
        mask_clr       = 1'b0;
        load_active    = 1'b0;
        commit_bank    = 1'b0;

        // FIR lost its coefficients while disabled; re-send once it is back
        if (i_enable && !enable_q) restore_pend_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (restore_pend_q) begin
                    state_d        = ARMED;
                    restore_pend_d = 1'b0;
                    restoring_d    = 1'b1;
                    load_active    = 1'b1;
                    cnt_d          = '0;
                end else if (i_start) begin
                    state_d  = LOAD;
                    mask_clr = 1'b1;
                    error_d  = '0;
                end
            end
            LOAD: begin
                if (wr_fire && !addr_ok) error_d[ERR_ADDR] = 1'b1;
                if (i_abort) begin
                    state_d  = IDLE;
                    mask_clr = 1'b1;
                end else if (i_commit) begin
                    if (mask_full) begin
                        state_d     = ARMED;
                        restoring_d = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        error_d[ERR_INCOMPLETE] = 1'b1;
                    end
                end
            end
            ARMED: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_abort) begin
                    state_d  = IDLE;
                    mask_clr = 1'b1;
                end else if (window_open) begin
                    state_d     = COMMIT;
                    commit_bank = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    // Shadow and mask are kept so the user can simply re-commit
                    state_d              = LOAD;
                    error_d[ERR_TIMEOUT] = 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (!restoring_q) bank_id_d = ~bank_id_q;
            end
            default: state_d = IDLE;
        endcase

        // Disable overrides everything except the retained active bank
        if (!i_enable) begin
            state_d        = IDLE;
            mask_clr       = 1'b1;
            error_d        = '0;
            cnt_d          = '0;
            restore_pend_d = 1'b0;
            load_active    = 1'b0;
            commit_bank    = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            error_q        <= '0;
            restore_pend_q <= 1'b0;
            restoring_q    <= 1'b0;
            bank_id_q      <= 1'b0;
            enable_q       <= 1'b1;  // no restore for an enable already high out of reset
            commit_done_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            error_q        <= error_d;
            restore_pend_q <= restore_pend_d;
            restoring_q    <= restoring_d;
            bank_id_q      <= bank_id_d;
            enable_q       <= i_enable;
            commit_done_q  <= (state_q == COMMIT);
        end
    end

    assign o_state       = state_q;
    assign o_wr_ready    = (state_q == LOAD);
    assign o_coeff_valid = (state_q == COMMIT);
    assign o_commit_done = commit_done_q;
    assign o_bank_id     = bank_id_q;
    assign o_error       = error_q;

endmodule

// File: tb/tb_ssemi_fir_coeff_ctrl.sv
// Scoreboard bench for ssemi_fir_coeff_ctrl: a 64-tap and a 48-tap instance.
// Build option: SSEMI_FIR_COEFF_SYMMETRIC_EN switches the expected loading model.
module tb_ssemi_fir_coeff_ctrl;

    localparam int NA = 64;
    localparam int NB = 48;
    localparam int W  = 16;
`ifdef SSEMI_FIR_COEFF_SYMMETRIC_EN
    localparam bit SYM = 1'b1;
`else
    localparam bit SYM = 1'b0;
`endif
    localparam int LIMA  = SYM ? (NA + 1) / 2 : NA;
    localparam int LIMB  = SYM ? (NB + 1) / 2 : NB;
    localparam int MISSA = SYM ? 20 : 40;

    typedef struct {
        logic [NA*W-1:0] bank;
        logic            bank_id;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    exp_t qa[$];
    exp_t qb[$];
    logic [W-1:0] sha [NA];
    logic [W-1:0] acta[NA];
    logic [W-1:0] shb [NB];
    logic         bida = 1'b0;
    logic         bidb = 1'b0;

    // DUT A signals
    logic a_enable, a_start, a_wr_valid, a_wr_ready, a_commit, a_abort, a_busy, a_ready;
    logic [5:0]      a_wr_addr;
    logic [W-1:0]    a_wr_data;
    logic [NA*W-1:0] a_coeff;
    logic a_valid, a_done, a_bid;
    logic [1:0] a_state;
    logic [2:0] a_error;
    // DUT B signals
    logic b_start, b_wr_valid, b_wr_ready, b_commit;
    logic [5:0]      b_wr_addr;
    logic [W-1:0]    b_wr_data;
    logic [NB*W-1:0] b_coeff;
    logic b_valid, b_done, b_bid;
    logic [1:0] b_state;
    logic [2:0] b_error;

    ssemi_fir_coeff_ctrl #(
        .NUM_TAPS(NA), .COEFF_WIDTH(W), .BOUNDARY_TIMEOUT(1024)
    ) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(a_enable), .i_start(a_start),
        .i_wr_valid(a_wr_valid), .o_wr_ready(a_wr_ready), .i_wr_addr(a_wr_addr),
        .i_wr_data(a_wr_data), .i_commit(a_commit), .i_abort(a_abort), .i_fir_busy(a_busy),
        .i_fir_coeff_ready(a_ready), .o_coeff(a_coeff), .o_coeff_valid(a_valid),
        .o_commit_done(a_done), .o_bank_id(a_bid), .o_state(a_state), .o_error(a_error)
    );

    ssemi_fir_coeff_ctrl #(
        .NUM_TAPS(NB), .COEFF_WIDTH(W), .BOUNDARY_TIMEOUT(64)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(1'b1), .i_start(b_start),
        .i_wr_valid(b_wr_valid), .o_wr_ready(b_wr_ready), .i_wr_addr(b_wr_addr),
        .i_wr_data(b_wr_data), .i_commit(b_commit), .i_abort(1'b0), .i_fir_busy(1'b0),
        .i_fir_coeff_ready(1'b1), .o_coeff(b_coeff), .o_coeff_valid(b_valid),
        .o_commit_done(b_done), .o_bank_id(b_bid), .o_state(b_state), .o_error(b_error)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_bank(string name, logic [NA*W-1:0] act, logic [NA*W-1:0] exp, int taps);
        int bad = -1;
        n_chk++;
        for (int i = taps - 1; i >= 0; i--) begin
            if (act[i*W +: W] !== exp[i*W +: W]) bad = i;
        end
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: tap %0d got 0x%0h, required 0x%0h", name, bad,
                     act[bad*W +: W], exp[bad*W +: W]);
        end
    endtask

    function automatic logic [NA*W-1:0] pack_sha();
        logic [NA*W-1:0] v = '0;
        for (int i = 0; i < NA; i++) v[i*W +: W] = sha[i];
        return v;
    endfunction

    function automatic logic [NA*W-1:0] pack_acta();
        logic [NA*W-1:0] v = '0;
        for (int i = 0; i < NA; i++) v[i*W +: W] = acta[i];
        return v;
    endfunction

    function automatic logic [NA*W-1:0] pack_shb();
        logic [NA*W-1:0] v = '0;
        for (int i = 0; i < NB; i++) v[i*W +: W] = shb[i];
        return v;
    endfunction

    task automatic push(bit b, logic [NA*W-1:0] bank, logic bid, int c);
        exp_t e;
        e.bank = bank;
        e.bank_id = bid;
        e.cyc = c;
        if (b) qb.push_back(e);
        else qa.push_back(e);
    endtask

    task automatic go(bit b);
        if (b) b_start = 1'b1;
        else a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    // Drive a write and update the reference shadow model
    task automatic drive_wr(bit b, int addr, int data);
        if (b) begin
            b_wr_valid = 1'b1;
            b_wr_addr  = 6'(addr);
            b_wr_data  = W'(data);
            if (addr < LIMB) begin
                shb[addr] = W'(data);
                if (SYM) shb[NB-1-addr] = W'(data);
            end
        end else begin
            a_wr_valid = 1'b1;
            a_wr_addr  = 6'(addr);
            a_wr_data  = W'(data);
            if (addr < LIMA) begin
                sha[addr] = W'(data);
                if (SYM) sha[NA-1-addr] = W'(data);
            end
        end
    endtask

    task automatic wr(bit b, int addr, int data);
        drive_wr(b, addr, data);
        @(negedge clk);
        a_wr_valid = 1'b0;
        b_wr_valid = 1'b0;
    endtask

    // Commit request; 'ok' means a pulse must follow two cycles later
    task automatic cmt(bit b, bit with_wr, int addr, int data, bit ok);
        if (with_wr) drive_wr(b, addr, data);
        if (b) b_commit = 1'b1;
        else a_commit = 1'b1;
        if (ok) begin
            if (b) begin
                bidb = ~bidb;
                push(1'b1, pack_shb(), bidb, cyc + 2);
            end else begin
                bida = ~bida;
                push(1'b0, pack_sha(), bida, cyc + 2);
                for (int i = 0; i < NA; i++) acta[i] = sha[i];
            end
        end
        @(negedge clk);
        a_commit = 1'b0;
        b_commit = 1'b0;
        a_wr_valid = 1'b0;
        b_wr_valid = 1'b0;
    endtask

    // Monitor A: every valid pulse must match the oldest expectation
    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_valid === 1'b1) begin
                if (qa.size() == 0) begin
                    chk("a_valid_expected", 64'(qa.size()), 64'd1);
                end else begin
                    e = qa.pop_front();
                    chk_bank("a_coeff_on_valid", a_coeff, e.bank, NA);
                    chk("a_valid_cycle", 64'(cyc), 64'(e.cyc));
                    @(negedge clk);
                    chk("a_valid_single", 64'(a_valid), 64'd0);
                    chk("a_commit_done", 64'(a_done), 64'd1);
                    chk("a_bank_id", 64'(a_bid), 64'(e.bank_id));
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (b_valid === 1'b1) begin
                if (qb.size() == 0) begin
                    chk("b_valid_expected", 64'(qb.size()), 64'd1);
                end else begin
                    e = qb.pop_front();
                    chk_bank("b_coeff_on_valid", (NA*W)'(b_coeff), e.bank, NB);
                    chk("b_valid_cycle", 64'(cyc), 64'(e.cyc));
                    @(negedge clk);
                    chk("b_valid_single", 64'(b_valid), 64'd0);
                    chk("b_commit_done", 64'(b_done), 64'd1);
                    chk("b_bank_id", 64'(b_bid), 64'(e.bank_id));
                end
            end
        end
    end

    initial begin : stim
        int n;
        rst_n = 1'b0;
        a_enable = 1'b1; a_start = 1'b0; a_wr_valid = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_commit = 1'b0; a_abort = 1'b0; a_busy = 1'b0; a_ready = 1'b1;
        b_start = 1'b0; b_wr_valid = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_commit = 1'b0;
        for (int i = 0; i < NA; i++) begin sha[i] = '0; acta[i] = '0; end
        for (int i = 0; i < NB; i++) shb[i] = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_state", 64'(a_state), 64'd0);
        chk_bank("rst_coeff", a_coeff, '0, NA);
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_wr_ready", 64'(a_wr_ready), 64'd0);
        chk("rst_bank_id", 64'(a_bid), 64'd0);
        chk("rst_error", 64'(a_error), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: full load, data = addr*3, open window
        go(1'b0);
        chk("t1_state_load", 64'(a_state), 64'd1);
        chk("t1_wr_ready", 64'(a_wr_ready), 64'd1);
        for (int i = 0; i < LIMA; i++) wr(1'b0, i, i * 3);
        cmt(1'b0, 1'b0, 0, 0, 1'b1);
        repeat (3) @(negedge clk);
        chk("t1_tap5", 64'(a_coeff[5*W +: W]), 64'd15);
        chk("t1_state_idle", 64'(a_state), 64'd0);
        chk("t1_bank_id", 64'(a_bid), 64'd1);

        // 2: one tap missing, then write it together with the commit
        go(1'b0);
        for (int i = 0; i < LIMA; i++) begin
            if (i != MISSA) wr(1'b0, i, i * 5 - 100);
        end
        cmt(1'b0, 1'b0, 0, 0, 1'b0);
        chk("t2_incomplete_err", 64'(a_error), 64'h2);
        @(negedge clk);
        chk("t2_stay_load", 64'(a_state), 64'd1);
        cmt(1'b0, 1'b1, MISSA, MISSA * 5 - 100, 1'b1);
        repeat (3) @(negedge clk);
        chk("t2_err_sticky", 64'(a_error), 64'h2);
        chk("t2_bank_id", 64'(a_bid), 64'd0);

        // 3: 48 taps, out-of-range write, mask untouched
        go(1'b1);
        for (int i = 0; i < LIMB - 1; i++) wr(1'b1, i, i * 11 + 3);
        wr(1'b1, 50, 'h7777);
        chk("t3_addr_err", 64'(b_error), 64'h1);
        cmt(1'b1, 1'b0, 0, 0, 1'b0);
        chk("t3_mask_unchanged", 64'(b_error), 64'h3);
        chk("t3_stay_load", 64'(b_state), 64'd1);
        cmt(1'b1, 1'b1, LIMB - 1, (LIMB - 1) * 11 + 3, 1'b1);
        repeat (3) @(negedge clk);
        chk("t3_tap47", 64'(b_coeff[47*W +: W]), SYM ? 64'd3 : 64'd520);
        chk("t3_bank_id", 64'(b_bid), 64'd1);

        // 4: boundary never opens, timeout back to LOAD, then commit
        go(1'b0);
        for (int i = 0; i < LIMA; i++) wr(1'b0, i, 7 * i + 1);
        a_busy = 1'b1;
        cmt(1'b0, 1'b0, 0, 0, 1'b0);
        chk("t4_armed", 64'(a_state), 64'd2);
        n = 0;
        while (a_state != 2'd1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_timeout_cycles", 64'(n), 64'd1024);
        chk("t4_state_load", 64'(a_state), 64'd1);
        chk("t4_timeout_err", 64'(a_error), 64'h4);
        a_busy = 1'b0;
        cmt(1'b0, 1'b0, 0, 0, 1'b1);
        repeat (3) @(negedge clk);
        chk("t4_bank_id", 64'(a_bid), 64'd1);

        // 5: abort while armed keeps the active bank
        go(1'b0);
        for (int i = 0; i < LIMA; i++) wr(1'b0, i, i ^ 'h55);
        a_busy = 1'b1;
        cmt(1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        chk("t5_armed", 64'(a_state), 64'd2);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        a_busy = 1'b0;
        chk("t5_idle", 64'(a_state), 64'd0);
        chk_bank("t5_coeff_kept", a_coeff, pack_acta(), NA);
        repeat (3) @(negedge clk);
        chk("t5_bank_id", 64'(a_bid), 64'd1);

        // 6: disable clears errors, re-enable re-commits the active bank
        go(1'b0);
        cmt(1'b0, 1'b0, 0, 0, 1'b0);
        chk("t6_err_before", 64'(a_error), 64'h2);
        a_enable = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_idle", 64'(a_state), 64'd0);
        chk("t6_err_cleared", 64'(a_error), 64'd0);
        chk_bank("t6_coeff_retained", a_coeff, pack_acta(), NA);
        a_enable = 1'b1;
        push(1'b0, pack_acta(), bida, cyc + 3);
        repeat (6) @(negedge clk);
        chk("t6_err_after", 64'(a_error), 64'd0);
        chk("t6_bank_id", 64'(a_bid), 64'd1);

        repeat (4) @(negedge clk);
        chk("a_queue_drained", 64'(qa.size()), 64'd0);
        chk("b_queue_drained", 64'(qb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
